// File: rtl/ddram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddram_pkg                                                            |
// | Shared DDRAM write-path widths, entry record and byte-merge helper.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ddram_pkg;
   localparam int DDRAM_AW  = 29;
   localparam int DDRAM_DW  = 64;
   localparam int DDRAM_BEW = 8;
   localparam int ENTRY_W   = DDRAM_AW + DDRAM_DW + DDRAM_BEW;

   typedef struct packed {
      logic [DDRAM_AW-1:0]  addr;
      logic [DDRAM_DW-1:0]  din;
      logic [DDRAM_BEW-1:0] be;
   } ddram_entry_t;

   function automatic logic [DDRAM_DW-1:0] merge_bytes(
      input logic [DDRAM_DW-1:0]  old_d,
      input logic [DDRAM_DW-1:0]  new_d,
      input logic [DDRAM_BEW-1:0] be
   );
      logic [DDRAM_DW-1:0] r;
      r = old_d;
      for (int i = 0; i < DDRAM_BEW; i++)
         if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
      return r;
   endfunction
endpackage
`default_nettype wire

// File: rtl/wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wr_fifo                                                              |
// | Single-clock show-ahead FIFO; a push into a full FIFO is accepted    |
// | only when a pop frees a slot on the same edge.                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wr_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 101,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (r_level == '0);
   assign full      = (r_level == (AW+1)'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign rdata     = r_mem[r_rd_ptr];
   assign level     = r_level;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/ddram_wr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddram_wr_buffer                                                      |
// | Byte-merging write combiner feeding a FIFO and a one-deep DDRAM      |
// | write port with backpressure and sticky overflow.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ddram_wr_buffer
   import ddram_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int IDLE_MAX = 8
) (
   input  logic                   CLK_VIDEO,
   input  logic                   reset,
   input  logic                   in_we,
   input  logic [DDRAM_AW-1:0]    in_addr,
   input  logic [DDRAM_DW-1:0]    in_din,
   input  logic [DDRAM_BEW-1:0]   in_be,
   input  logic                   flush,
   input  logic                   clr_ovf,
   input  logic                   DDRAM_BUSY,
   output logic                   DDRAM_WE,
   output logic [DDRAM_AW-1:0]    DDRAM_ADDR,
   output logic [DDRAM_DW-1:0]    DDRAM_DIN,
   output logic [DDRAM_BEW-1:0]   DDRAM_BE,
   output logic [7:0]             DDRAM_BURSTCNT,
   output logic                   DDRAM_RD,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf
);
   localparam int         c_IDLE_W  = $clog2(IDLE_MAX + 1);
   localparam logic [0:0] c_S_IDLE  = 1'b0;
   localparam logic [0:0] c_S_WRITE = 1'b1;

   ddram_entry_t          r_mr;
   logic                  r_mr_valid;
   logic                  r_mr_force;
   logic [c_IDLE_W-1:0]   r_idle_cnt;
   ddram_entry_t          r_out;
   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic                  r_ovf;
   ddram_entry_t          w_fifo_rdata;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_mergeable;
   logic                  w_idle_hit;

   // A flushed write is marked forced so it can never absorb a later write.
   assign w_mergeable = in_we & r_mr_valid & ~r_mr_force & ~flush
                      & (in_addr == r_mr.addr) & ((in_be & r_mr.be) == '0);
   assign w_idle_hit  = ~in_we & (r_idle_cnt == c_IDLE_W'(IDLE_MAX - 1));
   assign w_push      = r_mr_valid & ((in_we & ~w_mergeable)
                      | (~in_we & (flush | r_mr_force | w_idle_hit)));

   always_ff @(posedge CLK_VIDEO) begin
      if (reset) begin
         r_mr       <= '0;
         r_mr_valid <= 1'b0;
         r_mr_force <= 1'b0;
         r_idle_cnt <= '0;
      end else if (in_we) begin
         r_idle_cnt <= '0;
         if (w_mergeable) begin
            r_mr.be  <= r_mr.be | in_be;
            r_mr.din <= merge_bytes(r_mr.din, in_din, in_be);
         end else begin
            r_mr       <= '{addr: in_addr, din: in_din, be: in_be};
            r_mr_valid <= 1'b1;
            r_mr_force <= flush;
         end
      end else if (w_push) begin
         r_mr_valid <= 1'b0;
         r_mr_force <= 1'b0;
         r_idle_cnt <= '0;
      end else if (r_mr_valid) begin
         r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
      end
   end

   wr_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk   (CLK_VIDEO),
      .rst   (reset),
      .push  (w_push),
      .wdata (r_mr),
      .pop   (w_pop),
      .rdata (w_fifo_rdata),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   always_ff @(posedge CLK_VIDEO) begin
      if (reset)                        r_ovf <= 1'b0;
      else if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      else if (clr_ovf)                 r_ovf <= 1'b0;
   end

   always_ff @(posedge CLK_VIDEO) begin
      if (reset) r_state <= c_S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE:  if (!w_empty)   w_state_nxt = c_S_WRITE;
         c_S_WRITE: if (!DDRAM_BUSY) w_state_nxt = w_empty ? c_S_IDLE : c_S_WRITE;
         default:                   w_state_nxt = c_S_IDLE;
      endcase
   end

   always_comb begin
      DDRAM_WE = (r_state == c_S_WRITE);
      w_pop    = ~w_empty & ((r_state == c_S_IDLE) | ~DDRAM_BUSY);
   end

   always_ff @(posedge CLK_VIDEO) begin
      if (reset)      r_out <= '0;
      else if (w_pop) r_out <= w_fifo_rdata;
   end

   assign DDRAM_ADDR     = r_out.addr;
   assign DDRAM_DIN      = r_out.din;
   assign DDRAM_BE       = r_out.be;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_RD       = 1'b0;
   assign ovf            = r_ovf;
endmodule
`default_nettype wire
